// File: rtl/fetch_sequencer.sv
// fetch_sequencer: byte-serial instruction fetch FSM. Reads the opcode, asks the
// external decoder for the length, reads up to two operand bytes and then holds
// the complete instruction until execute accepts it.
// Optional feature: define V6502_RESET_VECTOR_EN to boot through the FFFC/FFFD
// reset vector; without it the fetch starts directly at 16'h0200.
module fetch_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] mem_addr,
   output logic        mem_rd,
   input  logic [7:0]  mem_rdata,
   input  logic        mem_ready,
   output logic [7:0]  opcode,
   input  logic [1:0]  inst_len,
   output logic [15:0] operand,
   output logic [15:0] inst_pc,
   output logic        inst_valid,
   input  logic        exec_ready,
   input  logic        br_taken,
   input  logic [15:0] br_target
);

`ifdef V6502_RESET_VECTOR_EN
   typedef enum logic [2:0] {
      VEC_LO = 3'd0,
      VEC_HI = 3'd1,
      OPC    = 3'd2,
      OP1    = 3'd3,
      OP2    = 3'd4,
      HOLD   = 3'd5
   } state_t;
   localparam state_t      RST_STATE = VEC_LO;
   localparam logic [15:0] RST_PC    = 16'hFFFC;
`else
   typedef enum logic [2:0] {
      OPC    = 3'd2,
      OP1    = 3'd3,
      OP2    = 3'd4,
      HOLD   = 3'd5
   } state_t;
   localparam state_t      RST_STATE = OPC;
   localparam logic [15:0] RST_PC    = 16'h0200;
`endif

   state_t      state;
   state_t      state_nxt;
   logic [15:0] pc;
   logic        rd_req;
   logic        xfer;
`ifdef V6502_RESET_VECTOR_EN
   logic [7:0]  vec_lo;
`endif

   // The address bus always shows the next fetch address; it only moves on a
   // completed transfer or an accepted redirect, so it is stable through waits.
   assign mem_addr = pc;
   // Gate the request with reset so a read is never presented while held in reset.
   assign mem_rd   = rd_req & rst_n;
   assign xfer     = rd_req & mem_ready;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= RST_STATE;
      else        state <= state_nxt;
   end

   // Next-state, read request and instruction-valid decode
   always_comb begin
      state_nxt  = state;
      rd_req     = 1'b0;
      inst_valid = 1'b0;
      case (state)
`ifdef V6502_RESET_VECTOR_EN
         VEC_LO: begin
            rd_req = 1'b1;
            if (mem_ready) state_nxt = VEC_HI;
         end
         VEC_HI: begin
            rd_req = 1'b1;
            if (mem_ready) state_nxt = OPC;
         end
`endif
         OPC: begin
            rd_req = 1'b1;
            if (mem_ready) state_nxt = OP1;
         end
         OP1: begin
            // Lengths 0 and 1 are both single-byte instructions: no operand read.
            if (inst_len > 2'd1) begin
               rd_req = 1'b1;
               if (mem_ready) state_nxt = (inst_len == 2'd3) ? OP2 : HOLD;
            end else begin
               state_nxt = HOLD;
            end
         end
         OP2: begin
            rd_req = 1'b1;
            if (mem_ready) state_nxt = HOLD;
         end
         HOLD: begin
            inst_valid = 1'b1;
            if (exec_ready) state_nxt = OPC;
         end
         default: state_nxt = RST_STATE;
      endcase
   end

   // Fetch pointer and instruction fields
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc      <= RST_PC;
         opcode  <= 8'hEA;
         operand <= 16'h0000;
         inst_pc <= 16'h0000;
`ifdef V6502_RESET_VECTOR_EN
         vec_lo  <= 8'h00;
`endif
      end else begin
         if (xfer) pc <= pc + 16'd1;
         case (state)
`ifdef V6502_RESET_VECTOR_EN
            VEC_LO: if (xfer) vec_lo <= mem_rdata;
            VEC_HI: if (xfer) pc <= {mem_rdata, vec_lo};
`endif
            OPC: begin
               if (xfer) begin
                  opcode  <= mem_rdata;
                  inst_pc <= pc;
                  operand <= 16'h0000;
               end
            end
            OP1:  if (xfer) operand[7:0] <= mem_rdata;
            OP2:  if (xfer) operand[15:8] <= mem_rdata;
            // Redirect only counts on the accept cycle of a held instruction.
            HOLD: if (exec_ready && br_taken) pc <= br_target;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized scoreboard bench for fetch_sequencer with a
// directed preamble (wait states, backpressure, redirect, address wrap) and a
// closing reset-during-operand-wait sequence. Honors V6502_RESET_VECTOR_EN.
module tb_fetch_sequencer;

   localparam int N = 60;
`ifdef V6502_RESET_VECTOR_EN
   localparam logic [15:0] RST_PC = 16'hFFFC;
`else
   localparam logic [15:0] RST_PC = 16'h0200;
`endif

   typedef struct {
      logic [7:0]  op;
      logic [15:0] pc;
      logic [15:0] opr;
      int          gap;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [15:0] mem_addr;
   logic        mem_rd;
   logic [7:0]  mem_rdata;
   logic        mem_ready;
   logic [7:0]  opcode;
   logic [1:0]  inst_len;
   logic [15:0] operand;
   logic [15:0] inst_pc;
   logic        inst_valid;
   logic        exec_ready;
   logic        br_taken;
   logic [15:0] br_target;

   logic [7:0]  mem [0:65535];
   int          plan_stall [N];
   bit          plan_br [N];
   logic [15:0] plan_tgt [N];
   exp_t        exp_q [$];

   int          errors = 0;
   int          checks = 0;
   bit          sb_on = 0;
   bit          manual = 0;
   int          presented = 0;
   int          drv_idx = 0;
   int          stall_left = 0;
   int          wctr = 0;
   logic [15:0] start_pc;

   fetch_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .opcode     (opcode),
      .inst_len   (inst_len),
      .operand    (operand),
      .inst_pc    (inst_pc),
      .inst_valid (inst_valid),
      .exec_ready (exec_ready),
      .br_taken   (br_taken),
      .br_target  (br_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Decoder model: two named opcodes, everything else takes its low two bits.
   function automatic logic [1:0] dec_len(input logic [7:0] op);
      if (op == 8'hAD) return 2'd3;
      if (op == 8'hEA) return 2'd1;
      return op[1:0];
   endfunction

   function automatic int eff_len(input logic [1:0] l);
      return (l < 2'd2) ? 1 : int'(l);
   endfunction

   assign inst_len  = dec_len(opcode);
   assign mem_rdata = mem[mem_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Memory responder: 2 waits per byte for the first instruction, zero-wait for
   // the next four, random afterwards; mem_ready is noise whenever no read is up.
   always @(negedge clk) begin
      if (!manual) begin
         if (!mem_rd) mem_ready = 1'($urandom_range(0, 1));
         else if (presented == 0) begin
            if (wctr < 2) begin
               mem_ready = 1'b0;
               wctr++;
            end else begin
               mem_ready = 1'b1;
               wctr = 0;
            end
         end
         else if (presented < 5) mem_ready = 1'b1;
         else mem_ready = ($urandom_range(0, 2) != 0);
      end
   end

   // Execute driver: follows the stall/branch plan on held instructions and
   // drives random exec_ready/br_taken noise otherwise.
   always @(negedge clk) begin
      if (inst_valid && drv_idx < N) begin
         if (stall_left > 0) begin
            exec_ready = 1'b0;
            br_taken   = 1'($urandom_range(0, 1));
            br_target  = 16'($urandom);
            stall_left--;
         end else begin
            exec_ready = 1'b1;
            br_taken   = plan_br[drv_idx];
            br_target  = plan_tgt[drv_idx];
            drv_idx++;
            if (drv_idx < N) stall_left = plan_stall[drv_idx];
         end
      end else begin
         exec_ready = inst_valid ? 1'b0 : 1'($urandom_range(0, 1));
         br_taken   = 1'($urandom_range(0, 1));
         br_target  = 16'($urandom);
      end
   end

   // Monitor: pops the scoreboard on each newly presented instruction and
   // checks hold/wait-state stability every cycle.
   always begin : monitor
      logic        prev_rd, prev_ready, prev_valid, tracking;
      logic [15:0] prev_addr, cap_pc, cap_opr;
      logic [7:0]  cap_op;
      int          run, gap, cur_idx;
      exp_t        e;
      prev_rd = 0; prev_ready = 0; prev_valid = 0; tracking = 0;
      prev_addr = 0; cap_pc = 0; cap_opr = 0; cap_op = 0;
      run = 0; gap = 0; cur_idx = -1;
      forever begin
         @(negedge clk);
         #1;
         if (sb_on) begin
            if (prev_rd && !prev_ready) begin
               chk("wait_rd_held", mem_rd, 1'b1);
               chk("wait_addr_stable", mem_addr, prev_addr);
            end
            if (inst_valid) begin
               chk("hold_no_rd", mem_rd, 1'b0);
               if (prev_valid) begin
                  run++;
                  if (tracking) begin
                     chk("hold_opcode_stable", opcode, cap_op);
                     chk("hold_operand_stable", operand, cap_opr);
                     chk("hold_inst_pc_stable", inst_pc, cap_pc);
                  end
               end else if (presented < N) begin
                  if (exp_q.size() == 0) begin
                     chk("scoreboard_nonempty", 0, 1);
                  end else begin
                     e = exp_q.pop_front();
                     chk("opcode", opcode, e.op);
                     chk("inst_pc", inst_pc, e.pc);
                     chk("operand", operand, e.opr);
                     if (presented >= 1 && presented <= 4) chk("latency", gap, e.gap);
                  end
                  cap_op = opcode; cap_opr = operand; cap_pc = inst_pc;
                  tracking = 1;
                  cur_idx = presented;
                  presented++;
                  run = 1;
                  gap = 0;
               end
            end else begin
               if (prev_valid && cur_idx == 1) chk("backpressure_hold_cycles", run, 6);
               tracking = 0;
               gap++;
            end
         end
         prev_rd    = mem_rd;
         prev_ready = mem_ready;
         prev_valid = inst_valid;
         prev_addr  = mem_addr;
      end
   end

   initial begin : main
      logic [15:0] p, a1, a2, nxt;
      logic [15:0] opr;
      logic [7:0]  op;
      int          l;
      bit          found;
      exp_t        e;

      rst_n = 1'b0; mem_ready = 1'b0;
      exec_ready = 1'b0; br_taken = 1'b0; br_target = 16'h0000;

      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
`ifdef V6502_RESET_VECTOR_EN
      mem[16'hFFFC] = 8'h00;
      mem[16'hFFFD] = 8'h80;
      start_pc = 16'h8000;
`else
      start_pc = 16'h0200;
`endif
      // Directed program: 3-byte with waits, 1-byte with backpressure,
      // 2-byte redirected to 9000, 3-byte redirected to FFFF, wrapping 2-byte.
      mem[start_pc]         = 8'hAD;
      mem[start_pc + 16'd1] = 8'h34;
      mem[start_pc + 16'd2] = 8'h12;
      mem[start_pc + 16'd3] = 8'hEA;
      mem[start_pc + 16'd4] = 8'h02;
      mem[start_pc + 16'd5] = 8'h77;
      mem[16'h9000] = 8'hAD;
      mem[16'h9001] = 8'h01;
      mem[16'h9002] = 8'h02;
      mem[16'hFFFF] = 8'h02;
      mem[16'h0000] = 8'h5A;

      for (int i = 0; i < N; i++) begin
         plan_stall[i] = $urandom_range(0, 3);
         plan_br[i]    = ($urandom_range(0, 3) == 0);
         plan_tgt[i]   = 16'($urandom);
      end
      plan_stall[0] = 0; plan_br[0] = 0;
      plan_stall[1] = 5; plan_br[1] = 0;
      plan_stall[2] = 0; plan_br[2] = 1; plan_tgt[2] = 16'h9000;
      plan_stall[3] = 1; plan_br[3] = 1; plan_tgt[3] = 16'hFFFF;
      plan_stall[4] = 0; plan_br[4] = 0;
      stall_left = plan_stall[0];

      // Reference trace: walk the memory image instruction by instruction.
      p = start_pc;
      for (int i = 0; i < N; i++) begin
         op  = mem[p];
         l   = eff_len(dec_len(op));
         a1  = p + 16'd1;
         a2  = p + 16'd2;
         opr = 16'h0000;
         if (l >= 2) opr[7:0]  = mem[a1];
         if (l == 3) opr[15:8] = mem[a2];
         e.op = op; e.pc = p; e.opr = opr; e.gap = (l == 3) ? 3 : 2;
         exp_q.push_back(e);
         p = plan_br[i] ? plan_tgt[i] : p + 16'(l);
      end

      repeat (3) @(negedge clk);
      #1;
      chk("reset_mem_rd", mem_rd, 1'b0);
      chk("reset_inst_valid", inst_valid, 1'b0);
      chk("reset_opcode", opcode, 8'hEA);
      chk("reset_operand", operand, 16'h0000);
      chk("reset_inst_pc", inst_pc, 16'h0000);
      chk("reset_mem_addr", mem_addr, RST_PC);

      @(posedge clk);
      #2;
      rst_n = 1'b1;
      sb_on = 1'b1;
      #1;
      chk("release_mem_rd", mem_rd, 1'b1);
      chk("release_mem_addr", mem_addr, RST_PC);

      for (int c = 0; c < 20000 && drv_idx < N; c++) @(negedge clk);
      chk("all_accepted", drv_idx, N);
      @(negedge clk);
      sb_on = 1'b0;
      chk("scoreboard_drained", exp_q.size(), 0);

      // Reset while waiting on an operand-low read.
      @(negedge clk);
      manual = 1'b1;
      mem_ready = 1'b0;
      rst_n = 1'b0;
      mem[start_pc] = 8'h02;
      nxt = start_pc + 16'd1;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      mem_ready = 1'b1;
      found = 0;
      for (int c = 0; c < 12 && !found; c++) begin
         @(negedge clk);
         if (mem_rd && mem_addr == nxt) begin
            mem_ready = 1'b0;
            found = 1;
         end
      end
      chk("op1_wait_reached", found, 1'b1);
      @(negedge clk);
      #1;
      chk("op1_wait_rd", mem_rd, 1'b1);
      chk("op1_wait_addr", mem_addr, nxt);
      rst_n = 1'b0;
      @(negedge clk);
      #1;
      chk("midreset_inst_valid", inst_valid, 1'b0);
      chk("midreset_mem_addr", mem_addr, RST_PC);
      chk("midreset_mem_rd", mem_rd, 1'b0);
      chk("midreset_opcode", opcode, 8'hEA);
      chk("midreset_operand", operand, 16'h0000);
      chk("midreset_inst_pc", inst_pc, 16'h0000);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      chk("midreset_release_rd", mem_rd, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001: The block SHALL use one clock, `clk`, and one reset, `rst_n`; reset is synchronous and active-low.
REQ-002: It SHALL provide these ports (name, direction, width, meaning):
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  sync active-low reset
- `mem_addr`  out  16  byte read address
- `mem_rd`  out  1  read request
- `mem_rdata`  in  8  read data, valid when `mem_ready`=1
- `mem_ready`  in  1  read completes this cycle when `mem_rd`=1
- `opcode`  out  8  latched opcode byte, fed to the decoder
- `inst_len`  in  2  decoder length for `opcode`, combinational; 0 and 1 both mean 1 byte
- `operand`  out  16  `{hi,lo}` operand; unused bytes are 0
- `inst_pc`  out  16  address of the current opcode
- `inst_valid`  out  1  instruction complete, offered to execute
- `exec_ready`  in  1  execute accepts the instruction
- `br_taken`  in  1  redirect; qualified by the accept cycle
- `br_target`  in  16  redirect address

Function
REQ-003: Internal 16-bit `pc` SHALL be the next fetch address. `mem_addr` SHALL equal `pc` in the OPC, OP1 and OP2 states.
REQ-004: The FSM states SHALL be VEC_LO, VEC_HI, OPC, OP1, OP2 and HOLD.
REQ-005: A byte transfer SHALL complete only on a cycle with `mem_rd`=1 and `mem_ready`=1.
- On that edge: `pc` increments by 1 (wraps FFFF->0000) and the byte is latched.
- Otherwise `mem_addr`/`mem_rd` hold stable.
REQ-006: In OPC, a completed transfer SHALL:
- latch `opcode`;
- latch `inst_pc` = `pc` before the increment;
- clear `operand`;
- go to OP1.
REQ-007: On entry to OP1, `inst_len` SHALL be sampled, and the next state chosen as follows:
- `inst_len`<=1: go to HOLD with no memory read (`mem_rd`=0).
- Otherwise: read the operand low byte, then go to OP2 if `inst_len`=3, else to HOLD.
REQ-008: In OP2, a completed transfer SHALL latch the operand high byte and go to HOLD.
REQ-009: In HOLD, `inst_valid`=1 and `mem_rd`=0.
- When `exec_ready`=1: go to OPC next cycle.
- `inst_valid` SHALL be 0 in every other state.
REQ-010: If `br_taken`=1 in the HOLD cycle where `exec_ready`=1, `pc` SHALL load `br_target`; otherwise `pc` is unchanged. `br_taken` SHALL be ignored in all other cycles.
REQ-011: Minimum latency with zero-wait memory, from OPC entry to `inst_valid`:
- 1-byte instruction: 2 cycles (OPC, OP1).
- 2-byte instruction: 2 cycles.
- 3-byte instruction: 3 cycles.
REQ-012: `opcode`, `operand` and `inst_pc` SHALL remain stable while `inst_valid`=1.
REQ-013: `mem_ready` with `mem_rd`=0 SHALL be ignored.

Reset
REQ-014: While `rst_n`=0 at a rising edge, including mid-transfer, the FSM SHALL take its reset state and all other outputs and registers their reset values; any pending read is abandoned:
- FSM: VEC_LO (or OPC, see REQ-016).
- `mem_rd`=0, `inst_valid`=0.
- `opcode`=8'hEA.
- `operand`=0, `inst_pc`=0.
- `mem_addr`=`pc` reset value.
REQ-015: On the first cycle after reset is released, `mem_rd` SHALL assert.

Configuration
REQ-016: Macro `V6502_RESET_VECTOR_EN` SHALL select the reset behaviour:
- Defined: reset `pc`=16'hFFFC and FSM=VEC_LO. VEC_LO reads FFFC (latch low), VEC_HI reads FFFD (latch high). Then `pc`={high,low} and go to OPC.
- Undefined: VEC_LO/VEC_HI are absent, reset `pc`=16'h0200 and FSM=OPC.

Verification
REQ-017: A bench SHALL cover these directed scenarios (stimulus -> required response):
- Vector fetch (macro on, zero-wait): FFFC=00, FFFD=80 -> first OPC `mem_addr`=8000.
- Wait states: 8000: AD 34 12 (`inst_len`=3), `mem_ready` low 2 cycles per byte -> `operand`=1234, `inst_pc`=8000, `pc`=8003; `mem_addr` stable during waits.
- Backpressure: 1-byte EA at 8003, `exec_ready`=0 for 5 cycles -> `inst_valid` held 5+ cycles, no `mem_rd`, outputs stable.
- Branch redirect: `br_taken`=1, `br_target`=9000 on accept -> next `mem_addr`=9000. `br_taken`=1 without `exec_ready` -> ignored.
- Wrap: `pc`=FFFF, `inst_len`=2 -> operand read at 0000, `pc`=0001.
- Reset mid-transfer: `rst_n`=0 during OP1 wait (macro off) -> next cycle `inst_valid`=0 and `mem_addr`=0200; `mem_rd`=1 after release.
